// File: rtl/jtag_intfc_pkg.sv
// Shared definitions for the JTAG packet interfaces: NI register map,
// NI status bit locations and the one-hot receiver state encoding.
package jtag_intfc_pkg;

  // NI register word offsets
  localparam logic [31:0] NI_STATUS_OFF   = 32'd0;
  localparam logic [31:0] NI_PCK_SIZE_OFF = 32'd3;
  localparam logic [31:0] NI_RD_MEM_OFF   = 32'd4;

  // NI status register bit locations
  localparam int unsigned NI_BUSY_LOC    = 0;
  localparam int unsigned NI_GOT_PCK_LOC = 1;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_POLL_PCK = 8'b0000_0010,
    ST_WAIT_PCK = 8'b0000_0100,
    ST_WR_SIZE  = 8'b0000_1000,
    ST_WR_PTR   = 8'b0001_0000,
    ST_WAIT_NI  = 8'b0010_0000,
    ST_POLL_NI  = 8'b0100_0000,
    ST_DONE     = 8'b1000_0000
  } rx_state_e;

endpackage

// File: rtl/rx_capture_ram.sv
// Capture buffer for received packet payload.
// One byte-enabled write port (NI slave writes) and two registered read
// ports: one for the host, one for slave read-back. Reads during a write
// to the same word return the old contents. Contents are never cleared.
// Ports:
//   clk                 clock
//   we/wsel/waddr/wdat  write port (byte enables in wsel)
//   host_raddr/rdat     host read port, 1-cycle latency
//   bus_raddr/rdat      slave read-back port, 1-cycle latency
module rx_capture_ram #(
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32,
  parameter int unsigned SELw = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [SELw-1:0] wsel,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdat,
  input  logic [AW-1:0]   host_raddr,
  output logic [DW-1:0]   host_rdat,
  input  logic [AW-1:0]   bus_raddr,
  output logic [DW-1:0]   bus_rdat
);

  localparam int unsigned WORDS = 2**AW;
  localparam int unsigned BYTEw = DW / SELw;

  logic [DW-1:0] mem [WORDS];

  // Byte-lane write plus registered reads (old data on collision)
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < SELw; b++) begin
        if (wsel[b]) mem[waddr][b*BYTEw +: BYTEw] <= wdat[b*BYTEw +: BYTEw];
      end
    end
    host_rdat <= mem[host_raddr];
    bus_rdat  <= mem[bus_raddr];
  end

endmodule

// File: rtl/jtag_rx_intfc.sv
// JTAG-side packet receiver. When armed by the host it polls the NI status
// until a packet is pending, programs the NI packet size and the delivery
// pointer (this block's slave window), then polls until the NI is idle.
// The NI delivers flits through the slave port: offset 0 is the header,
// offsets 1..2**RD_RAMw go to the capture RAM, anything above is dropped.
// Ports:
//   clk, reset                      clock, async active-high reset
//   s_*                             WB slave (NI writes / reads back)
//   m_*                             WB master to NI registers
//   arm_i                           host arm level
//   host_rd_addr_i/host_rd_dat_o    host buffer read, 1-cycle latency
//   rcv_hdr_o/rcv_size_o            captured header, accepted write count
//   busy_o/done_o/ovf_o/err_o/irq   status; irq mirrors done_o
module jtag_rx_intfc
  import jtag_intfc_pkg::*;
#(
  parameter logic [31:0] NI_BASE_ADDR   = 32'h0,
  parameter logic [31:0] JTAG_BASE_ADDR = 32'h0,
  parameter int unsigned RD_RAMw        = 8,
  parameter int unsigned Dw             = 32,
  parameter int unsigned S_Aw           = RD_RAMw + 1,
  parameter int unsigned M_Aw           = 32,
  parameter int unsigned TAGw           = 3,
  parameter int unsigned SELw           = 4,
  parameter int unsigned POLL_WAIT      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Dw-1:0]      s_dat_i,
  input  logic [SELw-1:0]    s_sel_i,
  input  logic [S_Aw-1:0]    s_addr_i,
  input  logic [TAGw-1:0]    s_tag_i,
  input  logic               s_stb_i,
  input  logic               s_cyc_i,
  input  logic               s_we_i,
  output logic [Dw-1:0]      s_dat_o,
  output logic               s_ack_o,
  output logic               s_err_o,
  output logic               s_rty_o,
  output logic [SELw-1:0]    m_sel_o,
  output logic [Dw-1:0]      m_dat_o,
  output logic [M_Aw-1:0]    m_addr_o,
  output logic [TAGw-1:0]    m_tag_o,
  output logic               m_stb_o,
  output logic               m_cyc_o,
  output logic               m_we_o,
  input  logic [Dw-1:0]      m_dat_i,
  input  logic               m_ack_i,
  input  logic               m_err_i,
  input  logic               m_rty_i,
  input  logic               arm_i,
  input  logic [RD_RAMw-1:0] host_rd_addr_i,
  output logic [Dw-1:0]      host_rd_dat_o,
  output logic [Dw-1:0]      rcv_hdr_o,
  output logic [RD_RAMw:0]   rcv_size_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o,
  output logic               err_o,
  output logic               irq
);

  localparam int unsigned RAM_WORDS = 2**RD_RAMw;
  localparam int unsigned SIZEw     = RD_RAMw + 1;
  localparam int unsigned BYTEw     = Dw / SELw;
  localparam int unsigned CNTw      = (POLL_WAIT > 1) ? $clog2(POLL_WAIT) : 1;

  localparam logic [M_Aw-1:0] ADDR_STATUS   = M_Aw'(NI_BASE_ADDR + NI_STATUS_OFF);
  localparam logic [M_Aw-1:0] ADDR_PCK_SIZE = M_Aw'(NI_BASE_ADDR + NI_PCK_SIZE_OFF);
  localparam logic [M_Aw-1:0] ADDR_RD_MEM   = M_Aw'(NI_BASE_ADDR + NI_RD_MEM_OFF);
  // One word beyond the buffer so the NI never stalls on a full packet
  localparam logic [Dw-1:0]   PCK_SIZE_VAL  = Dw'(RAM_WORDS + 1);
  localparam logic [Dw-1:0]   RD_PTR_VAL    = Dw'(JTAG_BASE_ADDR << 2);

  rx_state_e         state, state_n;
  logic              arm_q;
  logic              arm_rise_c;
  logic [CNTw-1:0]   cnt;
  logic              wait_done_c;
  logic              bus_fail_c;
  logic              clr_c;
  logic              set_err_c;

  logic              accept_c;
  logic              is_hdr_c;
  logic              in_ram_c;
  logic              ram_we_c;
  logic [RD_RAMw-1:0] ram_addr_c;
  logic [SIZEw-1:0]  size_base_c;
  logic              rd_hdr_q;
  logic              rd_ram_q;
  logic [Dw-1:0]     bus_rdat;

  logic              unused_bits;
  assign unused_bits = &{1'b0, s_tag_i, m_dat_i};

  assign arm_rise_c  = arm_i & ~arm_q;
  assign wait_done_c = (cnt == CNTw'(POLL_WAIT - 1));
  assign bus_fail_c  = m_err_i | m_rty_i;
  assign irq         = done_o;
  assign s_err_o     = 1'b0;
  assign s_rty_o     = 1'b0;

  // State register, arm edge detect and poll spacing counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      arm_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      arm_q <= arm_i;
      if ((state == ST_WAIT_PCK || state == ST_WAIT_NI) && state_n == state) cnt <= cnt + CNTw'(1);
      else                                                                     cnt <= '0;
    end
  end

  // Next state and master bus outputs
  always_comb begin
    state_n   = state;
    m_stb_o   = 1'b0;
    m_cyc_o   = 1'b0;
    m_we_o    = 1'b0;
    m_sel_o   = '1;
    m_tag_o   = '0;
    m_addr_o  = ADDR_STATUS;
    m_dat_o   = '0;
    clr_c     = 1'b0;
    set_err_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_rise_c) begin
          clr_c   = 1'b1;
          state_n = ST_POLL_PCK;
        end
      end
      ST_POLL_PCK: begin
        m_stb_o = 1'b1;
        m_cyc_o = 1'b1;
        if (bus_fail_c) begin
          set_err_c = 1'b1;
          state_n   = ST_DONE;
        end else if (m_ack_i) begin
          state_n = m_dat_i[NI_GOT_PCK_LOC] ? ST_WR_SIZE : ST_WAIT_PCK;
        end
      end
      ST_WAIT_PCK: begin
        if (!arm_i)           state_n = ST_IDLE;
        else if (wait_done_c) state_n = ST_POLL_PCK;
      end
      ST_WR_SIZE: begin
        m_stb_o  = 1'b1;
        m_cyc_o  = 1'b1;
        m_we_o   = 1'b1;
        m_addr_o = ADDR_PCK_SIZE;
        m_dat_o  = PCK_SIZE_VAL;
        if (bus_fail_c) begin
          set_err_c = 1'b1;
          state_n   = ST_DONE;
        end else if (m_ack_i) begin
          state_n = ST_WR_PTR;
        end
      end
      ST_WR_PTR: begin
        m_stb_o  = 1'b1;
        m_cyc_o  = 1'b1;
        m_we_o   = 1'b1;
        m_addr_o = ADDR_RD_MEM;
        m_dat_o  = RD_PTR_VAL;
        if (bus_fail_c) begin
          set_err_c = 1'b1;
          state_n   = ST_DONE;
        end else if (m_ack_i) begin
          state_n = ST_WAIT_NI;
        end
      end
      ST_WAIT_NI: begin
        if (wait_done_c) state_n = ST_POLL_NI;
      end
      ST_POLL_NI: begin
        m_stb_o = 1'b1;
        m_cyc_o = 1'b1;
        if (bus_fail_c) begin
          set_err_c = 1'b1;
          state_n   = ST_DONE;
        end else if (m_ack_i) begin
          state_n = m_dat_i[NI_BUSY_LOC] ? ST_WAIT_NI : ST_DONE;
        end
      end
      ST_DONE: begin
        if (!arm_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      busy_o <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done_o <= (state_n == ST_DONE);
      if (clr_c)          err_o <= 1'b0;
      else if (set_err_c) err_o <= 1'b1;
    end
  end

  // Slave decode: one accept per ack cycle, offset 0 is the header
  assign accept_c    = s_stb_i & s_cyc_i & ~s_ack_o;
  assign is_hdr_c    = (s_addr_i == '0);
  assign in_ram_c    = !is_hdr_c && (s_addr_i <= S_Aw'(RAM_WORDS));
  assign ram_addr_c  = RD_RAMw'(s_addr_i - S_Aw'(1));
  assign ram_we_c    = accept_c & s_we_i & in_ram_c;
  // An arm clear and a same-cycle write both take effect
  assign size_base_c = clr_c ? '0 : rcv_size_o;

  // Slave response, header capture, size and overflow tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ack_o    <= 1'b0;
      rd_hdr_q   <= 1'b0;
      rd_ram_q   <= 1'b0;
      rcv_hdr_o  <= '0;
      rcv_size_o <= '0;
      ovf_o      <= 1'b0;
    end else begin
      s_ack_o  <= accept_c;
      rd_hdr_q <= is_hdr_c;
      rd_ram_q <= in_ram_c;
      if (clr_c) begin
        rcv_hdr_o  <= '0;
        rcv_size_o <= '0;
        ovf_o      <= 1'b0;
      end
      if (accept_c && s_we_i) begin
        if (is_hdr_c) begin
          for (int unsigned b = 0; b < SELw; b++) begin
            if (s_sel_i[b]) rcv_hdr_o[b*BYTEw +: BYTEw] <= s_dat_i[b*BYTEw +: BYTEw];
          end
        end else if (!in_ram_c) begin
          ovf_o <= 1'b1;
        end
        if (size_base_c != '1) rcv_size_o <= size_base_c + SIZEw'(1);
      end
    end
  end

  // Read-back data lines up with the registered ack
  assign s_dat_o = rd_hdr_q ? rcv_hdr_o : (rd_ram_q ? bus_rdat : '0);

  rx_capture_ram #(
    .AW   (RD_RAMw),
    .DW   (Dw),
    .SELw (SELw)
  ) u_ram (
    .clk        (clk),
    .we         (ram_we_c),
    .wsel       (s_sel_i),
    .waddr      (ram_addr_c),
    .wdat       (s_dat_i),
    .host_raddr (host_rd_addr_i),
    .host_rdat  (host_rd_dat_o),
    .bus_raddr  (ram_addr_c),
    .bus_rdat   (bus_rdat)
  );

endmodule

// File: tb/tb_jtag_rx_intfc.sv
// Bench for jtag_rx_intfc: bench-side NI register responder, NI flit
// writer on the slave port and a behavioural model of the capture buffer.
module tb_jtag_rx_intfc;

  localparam logic [31:0] NI_BASE   = 32'h0000_1000;
  localparam logic [31:0] JTAG_BASE = 32'h0000_0040;
  localparam int          PW        = 5;
  localparam int          WORDS     = 256;
  localparam int          SIZE_MAX  = 511;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_dat_i;
  logic [3:0]  s_sel_i;
  logic [8:0]  s_addr_i;
  logic [2:0]  s_tag_i;
  logic        s_stb_i, s_cyc_i, s_we_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o, s_err_o, s_rty_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_o, m_addr_o;
  logic [2:0]  m_tag_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i, m_err_i, m_rty_i;
  logic        arm_i;
  logic [7:0]  host_rd_addr_i;
  logic [31:0] host_rd_dat_o, rcv_hdr_o;
  logic [8:0]  rcv_size_o;
  logic        busy_o, done_o, ovf_o, err_o, irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model of what the NI has delivered
  logic [31:0] exp_ram [WORDS];
  bit          exp_valid [WORDS];
  logic [31:0] exp_hdr;
  int          exp_size;
  bit          exp_ovf;

  jtag_rx_intfc #(
    .NI_BASE_ADDR   (NI_BASE),
    .JTAG_BASE_ADDR (JTAG_BASE),
    .POLL_WAIT      (PW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_addr_i(s_addr_i), .s_tag_i(s_tag_i),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_we_i(s_we_i),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_addr_o(m_addr_o), .m_tag_o(m_tag_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .arm_i(arm_i), .host_rd_addr_i(host_rd_addr_i), .host_rd_dat_o(host_rd_dat_o),
    .rcv_hdr_o(rcv_hdr_o), .rcv_size_o(rcv_size_o),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .err_o(err_o), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    exp_hdr  = '0;
    exp_size = 0;
    exp_ovf  = 1'b0;
  endfunction

  function automatic void model_write(input int off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] cur;
    if (off == 0)          cur = exp_hdr;
    else if (off <= WORDS) cur = exp_ram[off-1];
    else                   cur = '0;
    for (int b = 0; b < 4; b++) if (sel[b]) cur[8*b +: 8] = d[8*b +: 8];
    if (off == 0) exp_hdr = cur;
    else if (off <= WORDS) begin
      exp_ram[off-1]   = cur;
      exp_valid[off-1] = 1'b1;
    end else exp_ovf = 1'b1;
    exp_size = (exp_size >= SIZE_MAX) ? SIZE_MAX : exp_size + 1;
  endfunction

  // Wait (bounded) for an NI register access; gap counts idle negedges
  task automatic ni_wait_req(output bit ok, output logic [31:0] addr, output logic we,
                             output logic [31:0] dat, output int gap);
    ok = 1'b0; gap = 0; addr = '0; we = 1'b0; dat = '0;
    for (int i = 0; i < 200; i++) begin
      if (m_stb_o && m_cyc_o) begin
        ok = 1'b1; addr = m_addr_o; we = m_we_o; dat = m_dat_o;
        break;
      end
      gap++;
      @(negedge clk);
    end
  endtask

  task automatic ni_ack(input logic [31:0] rdata);
    m_ack_i = 1'b1; m_dat_i = rdata;
    @(negedge clk);
    m_ack_i = 1'b0; m_dat_i = '0;
  endtask

  task automatic wb_write(input int off, input logic [31:0] d, input logic [3:0] sel, output bit acked);
    s_addr_i = 9'(off); s_dat_i = d; s_sel_i = sel;
    s_we_i = 1'b1; s_stb_i = 1'b1; s_cyc_i = 1'b1; acked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ack_o) begin acked = 1'b1; break; end
    end
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    model_write(off, d, sel);
  endtask

  task automatic wb_read(input int off, output logic [31:0] d, output bit acked);
    s_addr_i = 9'(off); s_we_i = 1'b0; s_stb_i = 1'b1; s_cyc_i = 1'b1; acked = 1'b0; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ack_o) begin acked = 1'b1; d = s_dat_o; break; end
    end
    s_stb_i = 1'b0; s_cyc_i = 1'b0;
  endtask

  task automatic host_read(input int a, output logic [31:0] d);
    host_rd_addr_i = 8'(a);
    @(negedge clk);
    d = host_rd_dat_o;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm_i = 1'b0;
    s_dat_i = '0; s_sel_i = '0; s_addr_i = '0; s_tag_i = '0;
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    m_dat_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
    host_rd_addr_i = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({m_stb_o, m_cyc_o, m_we_o} !== 3'b000) begin errors++; $display("FAIL reset_m_strobes: got %b want 000", {m_stb_o, m_cyc_o, m_we_o}); end
    checks++; if (m_sel_o !== 4'hF) begin errors++; $display("FAIL reset_m_sel: got %h want f", m_sel_o); end
    checks++; if (m_addr_o !== NI_BASE) begin errors++; $display("FAIL reset_m_addr: got %h want %h", m_addr_o, NI_BASE); end
    checks++; if (m_dat_o !== 32'h0) begin errors++; $display("FAIL reset_m_dat: got %h want 0", m_dat_o); end
    checks++; if ({s_ack_o, s_err_o, s_rty_o} !== 3'b000) begin errors++; $display("FAIL reset_s_resp: got %b want 000", {s_ack_o, s_err_o, s_rty_o}); end
    checks++; if (rcv_hdr_o !== 32'h0 || rcv_size_o !== 9'd0) begin errors++; $display("FAIL reset_capture: hdr %h size %0d want 0/0", rcv_hdr_o, rcv_size_o); end
    checks++; if ({busy_o, done_o, ovf_o, err_o, irq} !== 5'b0) begin errors++; $display("FAIL reset_status: got %b want 00000", {busy_o, done_o, ovf_o, err_o, irq}); end
  endtask

  // Arm, random number of empty polls, then NI programming writes
  task automatic test_poll_program();
    bit ok; logic [31:0] a, d; logic we; int gap;
    int misses = int'($urandom_range(1, 3));
    arm_i = 1'b1;
    for (int p = 0; p <= misses; p++) begin
      ni_wait_req(ok, a, we, d, gap);
      checks++; if (!ok || a !== NI_BASE || we !== 1'b0) begin errors++; $display("FAIL poll_pck_%0d: ok %0d addr %h we %b want addr %h we 0", p, ok, a, we, NI_BASE); end
      if (p > 0) begin
        checks++; if (gap !== PW) begin errors++; $display("FAIL poll_gap_%0d: got %0d want %0d", p, gap, PW); end
      end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL poll_busy_%0d: got %b want 1", p, busy_o); end
      ni_ack((p == misses) ? 32'h2 : 32'($urandom_range(0, 1)));
    end
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || a !== NI_BASE + 32'd3 || we !== 1'b1 || d !== 32'd257) begin errors++; $display("FAIL wr_size: addr %h we %b dat %0d want %h 1 257", a, we, d, NI_BASE + 32'd3); end
    ni_ack('0);
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || a !== NI_BASE + 32'd4 || we !== 1'b1 || d !== (JTAG_BASE << 2)) begin errors++; $display("FAIL wr_ptr: addr %h we %b dat %h want %h 1 %h", a, we, d, NI_BASE + 32'd4, JTAG_BASE << 2); end
    ni_ack('0);
  endtask

  // Header + 1..4 delivered while NI busy, then completion
  task automatic test_capture();
    bit ok; logic [31:0] a, d; logic we; int gap;
    wb_write(0, 32'hFF00_1200, 4'hF, ok);
    for (int i = 1; i <= 4; i++) begin
      wb_write(i, 32'(i), 4'hF, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cap_ack_%0d: no ack", i); end
    end
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || a !== NI_BASE || we !== 1'b0) begin errors++; $display("FAIL poll_ni_first: ok %0d addr %h we %b", ok, a, we); end
    ni_ack(32'h1);
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || gap !== PW) begin errors++; $display("FAIL poll_ni_gap: ok %0d gap %0d want %0d", ok, gap, PW); end
    ni_ack(32'h0);
    checks++; if ({done_o, irq, busy_o, m_stb_o} !== 4'b1100) begin errors++; $display("FAIL cap_done: done,irq,busy,stb %b want 1100", {done_o, irq, busy_o, m_stb_o}); end
    checks++; if (rcv_hdr_o !== 32'hFF00_1200) begin errors++; $display("FAIL cap_hdr: got %h want ff001200", rcv_hdr_o); end
    checks++; if (rcv_size_o !== 9'(exp_size) || exp_size != 5) begin errors++; $display("FAIL cap_size: got %0d want 5", rcv_size_o); end
    for (int i = 0; i < 4; i++) begin
      host_read(i, d);
      checks++; if (d !== exp_ram[i]) begin errors++; $display("FAIL cap_host_rd_%0d: got %h want %h", i, d, exp_ram[i]); end
    end
    wb_read(0, d, ok);
    checks++; if (!ok || d !== exp_hdr) begin errors++; $display("FAIL cap_s_rd_hdr: got %h want %h", d, exp_hdr); end
    wb_read(3, d, ok);
    checks++; if (!ok || d !== exp_ram[2]) begin errors++; $display("FAIL cap_s_rd_3: got %h want %h", d, exp_ram[2]); end
    wb_read(400, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL cap_s_rd_oor: ok %0d got %h want 0", ok, d); end
    checks++; if (rcv_size_o !== 9'(exp_size)) begin errors++; $display("FAIL cap_size_after_rd: got %0d want %0d", rcv_size_o, exp_size); end
  endtask

  // Write one past the buffer: dropped, flagged, still acked
  task automatic test_overflow();
    bit ok; logic [31:0] d;
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", ovf_o); end
    wb_write(WORDS + 1, $urandom, 4'hF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_ack: no ack"); end
    @(negedge clk);
    checks++; if (ovf_o !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %b want %b", ovf_o, exp_ovf); end
    checks++; if (rcv_size_o !== 9'(exp_size)) begin errors++; $display("FAIL ovf_size: got %0d want %0d", rcv_size_o, exp_size); end
    host_read(0, d);
    checks++; if (d !== exp_ram[0]) begin errors++; $display("FAIL ovf_ram0: got %h want %h", d, exp_ram[0]); end
  endtask

  // Random offsets/data/byte enables, collision read, then full readback
  task automatic test_random_writes();
    bit ok; logic [31:0] d, old_d, nd;
    int off; logic [3:0] sel;
    for (int n = 0; n < 16; n++) begin
      off = int'($urandom_range(1, WORDS));
      sel = exp_valid[off-1] ? 4'($urandom_range(1, 15)) : 4'hF;
      wb_write(off, $urandom, sel, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_ack_%0d: no ack off %0d", n, off); end
    end
    @(negedge clk);
    old_d = exp_ram[1];
    nd = $urandom;
    host_rd_addr_i = 8'd1;
    s_addr_i = 9'd2; s_dat_i = nd; s_sel_i = 4'hF; s_we_i = 1'b1; s_stb_i = 1'b1; s_cyc_i = 1'b1;
    @(negedge clk);
    d = host_rd_dat_o;
    checks++; if (s_ack_o !== 1'b1 || d !== old_d) begin errors++; $display("FAIL collide_old: ack %b got %h want %h", s_ack_o, d, old_d); end
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    model_write(2, nd, 4'hF);
    @(negedge clk);
    checks++; if (host_rd_dat_o !== nd) begin errors++; $display("FAIL collide_new: got %h want %h", host_rd_dat_o, nd); end
    for (int i = 0; i < WORDS; i++) begin
      if (exp_valid[i]) begin
        host_read(i, d);
        checks++; if (d !== exp_ram[i]) begin errors++; $display("FAIL rnd_host_rd_%0d: got %h want %h", i, d, exp_ram[i]); end
      end
    end
    for (int n = 0; n < 4; n++) begin
      off = int'($urandom_range(1, 4));
      wb_read(off, d, ok);
      checks++; if (!ok || d !== exp_ram[off-1]) begin errors++; $display("FAIL rnd_s_rd_%0d: got %h want %h", off, d, exp_ram[off-1]); end
    end
    checks++; if (rcv_size_o !== 9'(exp_size)) begin errors++; $display("FAIL rnd_size: got %0d want %0d", rcv_size_o, exp_size); end
  endtask

  task automatic test_saturation();
    bit ok;
    int need = SIZE_MAX + 3 - exp_size;
    for (int n = 0; n < need; n++) wb_write(300, $urandom, 4'hF, ok);
    @(negedge clk);
    checks++; if (rcv_size_o !== 9'(exp_size) || exp_size != SIZE_MAX) begin errors++; $display("FAIL size_sat: got %0d want %0d", rcv_size_o, SIZE_MAX); end
  endtask

  // Bus error on the pointer write forces DONE with err_o
  task automatic test_err();
    bit ok; logic [31:0] a, d; logic we; int gap;
    arm_i = 1'b0;
    @(negedge clk);
    checks++; if ({done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL disarm_idle: done,busy %b want 00", {done_o, busy_o}); end
    arm_i = 1'b1;
    model_clear();
    @(negedge clk);
    checks++; if (rcv_hdr_o !== exp_hdr || rcv_size_o !== 9'(exp_size) || ovf_o !== exp_ovf || busy_o !== 1'b1) begin errors++; $display("FAIL rearm_clear: hdr %h size %0d ovf %b busy %b want 0 0 0 1", rcv_hdr_o, rcv_size_o, ovf_o, busy_o); end
    ni_wait_req(ok, a, we, d, gap);
    ni_ack(32'h2);
    ni_wait_req(ok, a, we, d, gap);
    ni_ack('0);
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || a !== NI_BASE + 32'd4) begin errors++; $display("FAIL err_reach_ptr: ok %0d addr %h", ok, a); end
    m_err_i = 1'b1;
    @(negedge clk);
    m_err_i = 1'b0;
    checks++; if ({err_o, done_o, irq, m_stb_o} !== 4'b1110) begin errors++; $display("FAIL err_done: err,done,irq,stb %b want 1110", {err_o, done_o, irq, m_stb_o}); end
    arm_i = 1'b0;
    @(negedge clk);
    checks++; if ({busy_o, done_o, m_stb_o} !== 3'b000) begin errors++; $display("FAIL err_idle: busy,done,stb %b want 000", {busy_o, done_o, m_stb_o}); end
  endtask

  // Arm dropped while waiting between polls: back to idle, no NI access
  task automatic test_arm_drop();
    bit ok; logic [31:0] a, d; logic we; int gap; int seen = 0;
    arm_i = 1'b1;
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || err_o !== 1'b0) begin errors++; $display("FAIL drop_poll: ok %0d err %b want 1 0", ok, err_o); end
    ni_ack(32'h0);
    arm_i = 1'b0;
    m_ack_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b0;
    for (int i = 0; i < 3 * PW; i++) begin
      if (m_stb_o || m_cyc_o) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL drop_no_access: got %0d strobe cycles want 0", seen); end
    checks++; if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL drop_idle: busy,done %b want 00", {busy_o, done_o}); end
  endtask

  // Asynchronous reset while the size write is outstanding
  task automatic test_reset_mid();
    bit ok; logic [31:0] a, d; logic we; int gap;
    arm_i = 1'b1;
    ni_wait_req(ok, a, we, d, gap);
    ni_ack(32'h2);
    ni_wait_req(ok, a, we, d, gap);
    checks++; if (!ok || a !== NI_BASE + 32'd3 || we !== 1'b1) begin errors++; $display("FAIL rst_reach_size: ok %0d addr %h we %b", ok, a, we); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({m_stb_o, m_cyc_o, m_we_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_strobes: got %b want 000", {m_stb_o, m_cyc_o, m_we_o}); end
    checks++; if (m_addr_o !== NI_BASE || m_dat_o !== 32'h0 || busy_o !== 1'b0 || rcv_size_o !== 9'd0) begin errors++; $display("FAIL rst_mid_outputs: addr %h dat %h busy %b size %0d", m_addr_o, m_dat_o, busy_o, rcv_size_o); end
    arm_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({m_stb_o, busy_o, done_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_after: stb,busy,done %b want 000", {m_stb_o, busy_o, done_o}); end
  endtask

  initial begin
    test_reset();
    test_poll_program();
    test_capture();
    test_overflow();
    test_random_writes();
    test_saturation();
    test_err();
    test_arm_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
